// File: rtl/video_timing_detect.sv
// rtl/video_timing_detect.sv - measures sync polarity, line/frame totals and active area of a video stream
// and declares lock once the format repeats for LOCK_FRAMES frames after a reference frame.
module video_timing_detect #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 3,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vid_vs,
    input  logic             vid_hs,
    input  logic             vid_de,
    output logic             locked,
    output logic             fmt_change,
    output logic             hs_pol,
    output logic             vs_pol,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [21:0]      WD_LAST = 22'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       LOCK_N  = 8'(LOCK_FRAMES);

    logic vs_r_q, hs_r_q, de_r_q, de_prev_q, hs_n_prev_q, vs_n_prev_q;
    logic hs_pol_cur_q, vs_pol_cur_q;
    logic hs_n, vs_n, hs_edge, vs_edge, de_rise, de_fall, pol_diff;

    logic [CNT_W-1:0] hcnt_q, hcnt_d, htot_q, htot_d, decnt_q, decnt_d;
    logic [CNT_W-1:0] hact_q, hact_d, vtot_q, vtot_d, vact_q, vact_d;
    logic             line_started_q, line_started_d, htot_have_q, htot_have_d;
    logic             hact_have_q, hact_have_d, inv_q, inv_d;

    logic [1:0]       state_q, state_d;
    logic [7:0]       match_q, match_d;
    logic [21:0]      wd_q, wd_d;
    logic             seen_de_q, seen_de_d, fmt_change_q, fmt_change_d;
    logic             store, clear, timeout, frame_ok, match_ok;

    logic [CNT_W-1:0] sh_htot_q, sh_hact_q, sh_vtot_q, sh_vact_q;
    logic             sh_hpol_q, sh_vpol_q;

    // Syncs are normalised so the active level is always 1 before edge detection
    assign hs_n     = hs_r_q ~^ hs_pol_cur_q;
    assign vs_n     = vs_r_q ~^ vs_pol_cur_q;
    assign hs_edge  = hs_n & ~hs_n_prev_q;
    assign vs_edge  = vs_n & ~vs_n_prev_q;
    assign de_rise  = de_r_q & ~de_prev_q;
    assign de_fall  = ~de_r_q & de_prev_q;
    assign pol_diff = de_rise & (((~hs_r_q) != hs_pol_cur_q) | ((~vs_r_q) != vs_pol_cur_q));

    always_comb begin
        hcnt_d         = hcnt_q;
        htot_d         = htot_q;
        decnt_d        = decnt_q;
        hact_d         = hact_q;
        vtot_d         = vtot_q;
        vact_d         = vact_q;
        line_started_d = line_started_q;
        htot_have_d    = htot_have_q;
        hact_have_d    = hact_have_q;
        inv_d          = inv_q;
        if (vs_edge) begin
            // A coincident hsync edge opens the first line of the new frame
            hcnt_d         = hs_edge ? CNT_ONE : '0;
            vtot_d         = hs_edge ? CNT_ONE : '0;
            line_started_d = hs_edge;
            htot_d         = '0;
            decnt_d        = '0;
            hact_d         = '0;
            vact_d         = '0;
            htot_have_d    = 1'b0;
            hact_have_d    = 1'b0;
            inv_d          = 1'b0;
        end else begin
            if (hs_edge) begin
                if (line_started_q) begin
                    if (!htot_have_q) begin
                        htot_have_d = 1'b1;
                        htot_d      = hcnt_q;
                    end else if (hcnt_q != htot_q) begin
                        inv_d = 1'b1;
                    end
                end
                line_started_d = 1'b1;
                hcnt_d         = CNT_ONE;
                if (vtot_q == CNT_MAX) inv_d = 1'b1;
                else                   vtot_d = vtot_q + CNT_ONE;
            end else if (hcnt_q == CNT_MAX) begin
                inv_d = 1'b1;
            end else begin
                hcnt_d = hcnt_q + CNT_ONE;
            end

            if (de_rise) begin
                decnt_d = CNT_ONE;
                if (vact_q == CNT_MAX) inv_d = 1'b1;
                else                   vact_d = vact_q + CNT_ONE;
            end else if (de_r_q) begin
                if (decnt_q == CNT_MAX) inv_d = 1'b1;
                else                    decnt_d = decnt_q + CNT_ONE;
            end

            if (de_fall) begin
                if (!hact_have_q) begin
                    hact_have_d = 1'b1;
                    hact_d      = decnt_q;
                end else if (decnt_q != hact_q) begin
                    inv_d = 1'b1;
                end
            end

            if (pol_diff) inv_d = 1'b1;
        end
    end

    assign frame_ok = ~inv_q & htot_have_q & hact_have_q;
    assign match_ok = frame_ok & (htot_q == sh_htot_q) & (hact_q == sh_hact_q) &
                      (vtot_q == sh_vtot_q) & (vact_q == sh_vact_q) &
                      (hs_pol_cur_q == sh_hpol_q) & (vs_pol_cur_q == sh_vpol_q);
    assign timeout  = (wd_q == WD_LAST) & ~vs_edge;

    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        seen_de_d    = seen_de_q | de_rise;
        fmt_change_d = 1'b0;
        store        = 1'b0;
        clear        = 1'b0;
        if (vs_edge)              wd_d = 22'd1;
        else if (wd_q == WD_LAST) wd_d = wd_q;
        else                      wd_d = wd_q + 22'd1;

        if (timeout) begin
            state_d   = S_IDLE;
            match_d   = '0;
            seen_de_d = 1'b0;
            clear     = 1'b1;
        end else if (vs_edge) begin
            case (state_q)
                S_IDLE: begin
                    if (seen_de_q) state_d = S_MEASURE;
                end
                S_MEASURE: begin
                    if (frame_ok) begin
                        store   = 1'b1;
                        match_d = '0;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (match_ok) begin
                        match_d = match_q + 8'd1;
                        if (match_q + 8'd1 == LOCK_N) state_d = S_LOCKED;
                    end else if (frame_ok) begin
                        store   = 1'b1;
                        match_d = '0;
                    end else begin
                        match_d = '0;
                        state_d = S_MEASURE;
                    end
                end
                default: begin
                    if (!match_ok) begin
                        match_d      = '0;
                        state_d      = S_MEASURE;
                        fmt_change_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_r_q         <= 1'b0;
            hs_r_q         <= 1'b0;
            de_r_q         <= 1'b0;
            de_prev_q      <= 1'b0;
            hs_n_prev_q    <= 1'b0;
            vs_n_prev_q    <= 1'b0;
            hs_pol_cur_q   <= 1'b0;
            vs_pol_cur_q   <= 1'b0;
            hcnt_q         <= '0;
            htot_q         <= '0;
            decnt_q        <= '0;
            hact_q         <= '0;
            vtot_q         <= '0;
            vact_q         <= '0;
            line_started_q <= 1'b0;
            htot_have_q    <= 1'b0;
            hact_have_q    <= 1'b0;
            inv_q          <= 1'b0;
            state_q        <= S_IDLE;
            match_q        <= '0;
            wd_q           <= '0;
            seen_de_q      <= 1'b0;
            fmt_change_q   <= 1'b0;
            sh_htot_q      <= '0;
            sh_hact_q      <= '0;
            sh_vtot_q      <= '0;
            sh_vact_q      <= '0;
            sh_hpol_q      <= 1'b0;
            sh_vpol_q      <= 1'b0;
        end else begin
            vs_r_q         <= vid_vs;
            hs_r_q         <= vid_hs;
            de_r_q         <= vid_de;
            de_prev_q      <= de_r_q;
            hs_n_prev_q    <= hs_n;
            vs_n_prev_q    <= vs_n;
            if (de_rise) begin
                hs_pol_cur_q <= ~hs_r_q;
                vs_pol_cur_q <= ~vs_r_q;
            end
            hcnt_q         <= hcnt_d;
            htot_q         <= htot_d;
            decnt_q        <= decnt_d;
            hact_q         <= hact_d;
            vtot_q         <= vtot_d;
            vact_q         <= vact_d;
            line_started_q <= line_started_d;
            htot_have_q    <= htot_have_d;
            hact_have_q    <= hact_have_d;
            inv_q          <= inv_d;
            state_q        <= state_d;
            match_q        <= match_d;
            wd_q           <= wd_d;
            seen_de_q      <= seen_de_d;
            fmt_change_q   <= fmt_change_d;
            if (clear) begin
                sh_htot_q <= '0;
                sh_hact_q <= '0;
                sh_vtot_q <= '0;
                sh_vact_q <= '0;
                sh_hpol_q <= 1'b0;
                sh_vpol_q <= 1'b0;
            end else if (store) begin
                sh_htot_q <= htot_q;
                sh_hact_q <= hact_q;
                sh_vtot_q <= vtot_q;
                sh_vact_q <= vact_q;
                sh_hpol_q <= hs_pol_cur_q;
                sh_vpol_q <= vs_pol_cur_q;
            end
        end
    end

    assign locked     = (state_q == S_LOCKED);
    assign fmt_change = fmt_change_q;
    assign hs_pol     = sh_hpol_q;
    assign vs_pol     = sh_vpol_q;
    assign h_total    = sh_htot_q;
    assign h_active   = sh_hact_q;
    assign v_total    = sh_vtot_q;
    assign v_active   = sh_vact_q;

endmodule

// File: tb/tb_video_timing_detect.sv
// tb/tb_video_timing_detect.sv - directed bench for video_timing_detect using two scaled-down formats
// (A: 20x10 totals, 12x6 active, active-high syncs; B: 16x8 totals, 10x5 active, active-low syncs).
module tb_video_timing_detect;

    localparam int TO = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_vs, vid_hs, vid_de;
    logic        locked, fmt_change, hs_pol, vs_pol;
    logic [11:0] h_total, h_active, v_total, v_active;

    int n_checks = 0;
    int n_fail   = 0;
    int fc_cnt   = 0;

    video_timing_detect #(
        .CNT_W      (12),
        .LOCK_FRAMES(3),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vid_vs    (vid_vs),
        .vid_hs    (vid_hs),
        .vid_de    (vid_de),
        .locked    (locked),
        .fmt_change(fmt_change),
        .hs_pol    (hs_pol),
        .vs_pol    (vs_pol),
        .h_total   (h_total),
        .h_active  (h_active),
        .v_total   (v_total),
        .v_active  (v_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (fmt_change) fc_cnt <= fc_cnt + 1;

    function automatic int ht(input int f);  return (f == 0) ? 20 : 16; endfunction
    function automatic int ha(input int f);  return (f == 0) ? 12 : 10; endfunction
    function automatic int vt(input int f);  return (f == 0) ? 10 : 8;  endfunction
    function automatic int va(input int f);  return (f == 0) ? 6  : 5;  endfunction
    function automatic int vbp(input int f); return (f == 0) ? 3  : 2;  endfunction
    function automatic int pol(input int f); return (f == 0) ? 1  : 0;  endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sync pulses are two pixels/lines wide at the start of each line/frame; de starts at pixel 4.
    task automatic step(input int f, input int bad, input int l, input int p);
        logic hs_a, vs_a, de_v;
        int   run;
        @(negedge clk);
        hs_a   = (p < 2);
        vs_a   = (l < 2);
        run    = ha(f) - (((bad != 0) && (l == vbp(f) + 1)) ? 1 : 0);
        de_v   = (l >= vbp(f)) && (l < vbp(f) + va(f)) && (p >= 4) && (p < 4 + run);
        vid_hs = (pol(f) != 0) ? hs_a : ~hs_a;
        vid_vs = (pol(f) != 0) ? vs_a : ~vs_a;
        vid_de = de_v;
    endtask

    task automatic drive_lines(input int f, input int bad, input int l0, input int p0, input int l1);
        for (int l = l0; l < l1; l++)
            for (int p = (l == l0) ? p0 : 0; p < ht(f); p++)
                step(f, bad, l, p);
    endtask

    task automatic frames(input int f, input int bad, input int n);
        for (int k = 0; k < n; k++) drive_lines(f, bad, 0, 0, vt(f));
    endtask

    task automatic check_fmt(input int f, input string tag);
        check_eq({tag, "_h_total"},  h_total,  ht(f));
        check_eq({tag, "_h_active"}, h_active, ha(f));
        check_eq({tag, "_v_total"},  v_total,  vt(f));
        check_eq({tag, "_v_active"}, v_active, va(f));
        check_eq({tag, "_hs_pol"},   hs_pol,   pol(f));
        check_eq({tag, "_vs_pol"},   vs_pol,   pol(f));
    endtask

    // Vsync edge pixel goes in before posedge N: locked must still be low after N, high after N+1.
    task automatic lock_edge(input int f, input string tag);
        step(f, 0, 0, 0);
        @(posedge clk); #1;
        check_eq({tag, "_pre"}, locked, 0);
        step(f, 0, 0, 1);
        @(posedge clk); #1;
        check_eq({tag, "_locked"}, locked, 1);
        check_fmt(f, tag);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_locked"},   locked,     0);
        check_eq({tag, "_fmt_chg"},  fmt_change, 0);
        check_eq({tag, "_h_total"},  h_total,    0);
        check_eq({tag, "_h_active"}, h_active,   0);
        check_eq({tag, "_v_total"},  v_total,    0);
        check_eq({tag, "_v_active"}, v_active,   0);
        check_eq({tag, "_hs_pol"},   hs_pol,     0);
        check_eq({tag, "_vs_pol"},   vs_pol,     0);
    endtask

    initial begin
        int fc_before;
        rst    = 1'b1;
        vid_vs = 1'b0;
        vid_hs = 1'b0;
        vid_de = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Fresh lock on format A
        frames(0, 0, 5);
        lock_edge(0, "a");
        check_eq("a_no_fc", fc_cnt, 0);

        // Switch to format B at a frame boundary, then relock
        drive_lines(0, 0, 0, 2, vt(0));
        frames(1, 0, 1);
        @(posedge clk); #1;
        check_eq("b_unlock", locked, 0);
        check_eq("b_fc_pulse", fc_cnt, 1);
        frames(1, 0, 4);
        lock_edge(1, "b");
        check_eq("b_fc_once", fc_cnt, 1);

        // Short de run in one line of every frame
        drive_lines(1, 0, 0, 2, vt(1));
        frames(1, 1, 1);
        @(posedge clk); #1;
        check_eq("bad_hold", locked, 1);
        frames(1, 1, 1);
        @(posedge clk); #1;
        check_eq("bad_unlock", locked, 0);
        check_eq("bad_fc", fc_cnt, 2);
        frames(1, 1, 3);
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        @(posedge clk); #1;
        check_eq("bad_nolock", locked, 0);
        check_eq("bad_fc_once", fc_cnt, 2);

        // Reset, lock on A, then reset mid-frame while locked
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        frames(0, 0, 5);
        lock_edge(0, "r");
        drive_lines(0, 0, 0, 2, 5);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_zero("mid_rst");
        drive_lines(0, 0, 5, 0, vt(0));
        frames(0, 0, 4);
        lock_edge(0, "mr");

        // Inputs frozen after the vsync edge: watchdog drops lock with no fmt_change
        fc_before = fc_cnt;
        repeat (TO - 2) @(posedge clk);
        #1;
        check_eq("to_before", locked, 1);
        @(posedge clk); #1;
        check_zero("to");
        check_eq("to_no_fc", fc_cnt, fc_before);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
